shifter: RTL and testbench

SHIFTER -- requirements
Module: shifter

---
 rtl/shifter_pkg.sv | 14 +
 rtl/shifter_stage.sv | 30 +++
 rtl/shifter.sv | 62 ++++++
 tb/tb_shifter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the barrel shifter: opcode encoding and fixed widths.
package shifter_pkg;

   typedef enum logic [1:0] {
      SRL = 2'b00,
      SRA = 2'b01,
      SLL = 2'b10,
      ROR = 2'b11
   } shift_op_e;

   localparam int unsigned SHIFTER_WIDTH = 32;
   localparam int unsigned SHAMT_W       = 5;

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter stage: shifts data by DIST bits when en_i is set, otherwise passes it through.
module shifter_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  shift_op_e        op_i,
   input  logic             fill_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] shifted;

   // Right shifts share one path; the caller sets fill_i to the sign bit only for SRA.
   always_comb begin
      shifted = data_i;
      case (op_i)
         SRL, SRA: shifted = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
         SLL:      shifted = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
         ROR:      shifted = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
         default:  shifted = data_i;
      endcase
   end

   assign data_o = en_i ? shifted : data_i;

endmodule

// File: rtl/shifter.sv
// 32-bit logarithmic barrel shifter with a single registered output stage.
module shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in,
   input  logic [1:0]         shiftop,
   input  logic [SHAMT_W-1:0] shiftamt,
   input  logic               valid_in,
   output logic [WIDTH-1:0]   result,
   output logic               valid_out
);

   shift_op_e        op;
   logic             fill;
   logic [WIDTH-1:0] stage_data [0:SHAMT_W];
   logic [WIDTH-1:0] result_d, result_q;
   logic             valid_d, valid_q;

   assign op            = shift_op_e'(shiftop);
   assign fill          = (op == SRA) & in[WIDTH-1];
   assign stage_data[0] = in;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      shifter_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << k)
      ) u_stage (
         .data_i (stage_data[k]),
         .op_i   (op),
         .fill_i (fill),
         .en_i   (shiftamt[k]),
         .data_o (stage_data[k+1])
      );
   end

   always_comb begin
      result_d = result_q;
      valid_d  = 1'b0;
      if (valid_in) begin
         result_d = stage_data[SHAMT_W];
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign result    = result_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: directed vectors plus randomized traffic against an arithmetic model.
module tb_shifter;
   import shifter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_s;
   logic [1:0]  shiftop;
   logic [4:0]  shiftamt;
   logic        valid_in;
   logic [31:0] result;
   logic        valid_out;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [31:0] m_result;
   logic        m_valid;

   shifter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in_s),
      .shiftop   (shiftop),
      .shiftamt  (shiftamt),
      .valid_in  (valid_in),
      .result    (result),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input shift_op_e op, input logic [31:0] x,
                                             input logic [4:0] a);
      logic [63:0] dbl;
      case (op)
         SRL:     return x >> a;
         SRA:     return 32'($signed(x) >>> a);
         SLL:     return x << a;
         default: begin
            dbl = {x, x} >> a;
            return dbl[31:0];
         end
      endcase
   endfunction

   // One clock: drive inputs, advance past the edge, update the model, compare.
   task automatic apply(input logic r, input logic v, input shift_op_e op,
                        input logic [31:0] x, input logic [4:0] a);
      rst      = r;
      valid_in = v;
      shiftop  = op;
      in_s     = x;
      shiftamt = a;
      @(posedge clk);
      #1;
      if (r) begin
         m_result = 32'h0;
         m_valid  = 1'b0;
      end else if (v) begin
         m_result = ref_shift(op, x, a);
         m_valid  = 1'b1;
      end else begin
         m_valid  = 1'b0;
      end
      check("result", result, m_result);
      check("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
   endtask

   task automatic directed(input shift_op_e op, input logic [31:0] x, input logic [4:0] a,
                           input logic [31:0] exp);
      apply(1'b0, 1'b1, op, x, a);
      check($sformatf("dir op=%0d amt=%0d", op, a), result, exp);
   endtask

   task automatic idle_random();
      apply(1'b0, 1'b0, shift_op_e'($urandom_range(0, 3)), $urandom, 5'($urandom));
   endtask

   initial begin
      m_result = 32'h0;
      m_valid  = 1'b0;

      apply(1'b1, 1'b0, SRL, 32'h0, 5'd0);
      apply(1'b1, 1'b1, SLL, 32'hFFFF_FFFF, 5'd3);
      check("reset result", result, 32'h0);

      directed(SRL, 32'h0000_0001, 5'd1, 32'h0);
      directed(SRL, 32'h0000_0001, 5'd2, 32'h0);
      directed(SRL, 32'h0000_0001, 5'd3, 32'h0);
      directed(SRA, 32'h0000_0001, 5'd1, 32'h0);
      directed(SRA, 32'h0000_0001, 5'd2, 32'h0);
      directed(SRA, 32'h0000_0001, 5'd3, 32'h0);
      directed(SLL, 32'h0000_0001, 5'd1, 32'h2);
      directed(SLL, 32'h0000_0001, 5'd2, 32'h4);
      directed(SLL, 32'h0000_0001, 5'd3, 32'h8);
      directed(SRA, 32'h8000_0000, 5'd4, 32'hF800_0000);
      directed(SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
      directed(SRL, 32'h8000_0000, 5'd4, 32'h0800_0000);
      directed(ROR, 32'h0000_0001, 5'd1, 32'h8000_0000);
      directed(SRL, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5);
      directed(SRA, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5);
      directed(SLL, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5);
      directed(ROR, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5);
      directed(SRL, 32'h8000_0001, 5'd31, 32'h0000_0001);
      directed(SLL, 32'h8000_0001, 5'd31, 32'h8000_0000);
      directed(ROR, 32'h8000_0001, 5'd31, 32'h0000_0003);
      directed(SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
      directed(ROR, 32'h1234_5678, 5'd8, 32'h7812_3456);

      // Single pulse, then three idle cycles with junk inputs: result must hold.
      directed(SLL, 32'h0000_00F0, 5'd4, 32'h0000_0F00);
      for (int i = 0; i < 3; i++) begin
         idle_random();
         check("hold result", result, 32'h0000_0F00);
         check("hold valid", {31'b0, valid_out}, 32'h0);
      end

      // Reset coinciding with valid_in must leave no trace afterwards.
      apply(1'b1, 1'b1, ROR, 32'hDEAD_BEEF, 5'd7);
      check("rst+valid result", result, 32'h0);
      idle_random();
      idle_random();
      check("post-rst result", result, 32'h0);
      check("post-rst valid", {31'b0, valid_out}, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         logic [4:0] a;
         logic       v;
         case ($urandom_range(0, 7))
            0:       a = 5'd0;
            1:       a = 5'd31;
            default: a = 5'($urandom);
         endcase
         v = ($urandom_range(0, 3) != 0);
         apply(($urandom_range(0, 99) == 0), v, shift_op_e'($urandom_range(0, 3)), $urandom, a);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
